// File: rtl/pe_dispatch_ctrl_if.sv
// Handshake bundle for pe_dispatch_ctrl: command in, per-PE issue/result lanes, reduced result out.
// master = the dispatcher itself, slave = the command path plus PE array around it.
interface pe_dispatch_ctrl_if #(
  parameter int NUM_PE = 4,
  parameter int DATA_W = 16,
  parameter int RES_W  = 32,
  parameter int ACC_W  = 40,
  parameter int ID_W   = 4
);

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [NUM_PE*DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0]        cmd_b;
  logic [NUM_PE-1:0]        cmd_mask;
  logic [1:0]               cmd_mode;
  logic [ID_W-1:0]          cmd_id;

  logic [NUM_PE-1:0]        pe_in_valid;
  logic [NUM_PE-1:0]        pe_in_ready;
  logic [NUM_PE*DATA_W-1:0] pe_in_a;
  logic [NUM_PE*DATA_W-1:0] pe_in_b;

  logic [NUM_PE-1:0]        pe_out_valid;
  logic [NUM_PE-1:0]        pe_out_ready;
  logic [NUM_PE*RES_W-1:0]  pe_out_data;

  logic                     res_valid;
  logic                     res_ready;
  logic [ACC_W-1:0]         res_data;
  logic [ID_W-1:0]          res_id;
  logic                     res_err;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_mask, cmd_mode, cmd_id,
    output cmd_ready,
    output pe_in_valid, pe_in_a, pe_in_b,
    input  pe_in_ready,
    input  pe_out_valid, pe_out_data,
    output pe_out_ready,
    output res_valid, res_data, res_id, res_err,
    input  res_ready
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_mask, cmd_mode, cmd_id,
    input  cmd_ready,
    input  pe_in_valid, pe_in_a, pe_in_b,
    output pe_in_ready,
    output pe_out_valid, pe_out_data,
    input  pe_out_ready,
    input  res_valid, res_data, res_id, res_err,
    output res_ready
  );

endinterface

// File: rtl/pe_dispatch_ctrl.sv
// PE-array dispatcher/collector: issues one command to the masked lanes, reduces their results
// on the fly (SUM/MAX/MIN, signed) and returns a single tagged result, aborting on timeout.
module pe_dispatch_ctrl #(
  parameter int NUM_PE  = 4,
  parameter int DATA_W  = 16,
  parameter int RES_W   = 32,
  parameter int ACC_W   = 40,
  parameter int ID_W    = 4,
  parameter int TMO_CYC = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  pe_dispatch_ctrl_if.master bus
);

  localparam int TMO_W = $clog2(TMO_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_COLLECT  = 2'd2,
    S_OUTPUT   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_SUM  = 2'd0,
    MODE_MAX  = 2'd1,
    MODE_MIN  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  state_e                   r_state;
  state_e                   w_state_next;

  logic [NUM_PE*DATA_W-1:0] r_a;
  logic [DATA_W-1:0]        r_b;
  logic [NUM_PE-1:0]        r_mask;
  mode_e                    r_mode;
  logic [ID_W-1:0]          r_id;
  logic [NUM_PE-1:0]        r_issued;
  logic [NUM_PE-1:0]        r_collected;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_acc_loaded;
  logic [TMO_W-1:0]         r_tmo;
  logic                     r_err;

  logic                     w_accept;
  logic                     w_bad_cmd;
  logic                     w_busy;
  logic                     w_tmo_hit;
  logic                     w_all_issued;
  logic                     w_all_collected;
  logic                     w_abort;
  logic [NUM_PE-1:0]        w_in_valid;
  logic [NUM_PE-1:0]        w_out_ready;
  logic [NUM_PE-1:0]        w_in_hs;
  logic [NUM_PE-1:0]        w_out_hs;
  logic signed [ACC_W-1:0]  w_lane;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic                     w_loaded_next;

  // Lane-level handshake qualifiers derive from registered state only, so the
  // next-state logic below can depend on the handshakes without a combinational loop.
  assign w_in_valid      = (r_state == S_DISPATCH) ? (r_mask & ~r_issued)    : '0;
  assign w_out_ready     = (r_state == S_COLLECT)  ? (r_mask & ~r_collected) : '0;
  assign w_in_hs         = w_in_valid  & bus.pe_in_ready;
  assign w_out_hs        = w_out_ready & bus.pe_out_valid;

  assign w_accept        = (r_state == S_IDLE) && bus.cmd_valid;
  assign w_bad_cmd       = (bus.cmd_mask == '0) || (mode_e'(bus.cmd_mode) == MODE_RSVD);
  assign w_busy          = (r_state == S_DISPATCH) || (r_state == S_COLLECT);
  assign w_tmo_hit       = w_busy && (r_tmo == TMO_W'(TMO_CYC - 1));
  // Issue completion counts this cycle's handshakes; collection completion uses the registered
  // flags, which is what places res_valid two cycles after the last result handshake.
  assign w_all_issued    = ((r_issued | w_in_hs) & r_mask) == r_mask;
  assign w_all_collected = (r_collected & r_mask) == r_mask;

  assign bus.cmd_ready    = (r_state == S_IDLE);
  assign bus.pe_in_valid  = w_in_valid;
  assign bus.pe_out_ready = w_out_ready;
  assign bus.pe_in_a      = r_a;
  assign bus.pe_in_b      = {NUM_PE{r_b}};
  assign bus.res_valid    = (r_state == S_OUTPUT);
  assign bus.res_data     = r_acc;
  assign bus.res_id       = r_id;
  assign bus.res_err      = r_err;

  // NOTE: sequential state is updated with non-blocking assignments so every register samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every variable written here gets a default first; a path that leaves one unassigned
  // would infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          w_state_next = w_bad_cmd ? S_OUTPUT : S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if (w_tmo_hit) begin
          w_state_next = S_OUTPUT;
          w_abort      = 1'b1;
        end else if (w_all_issued) begin
          w_state_next = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (w_all_collected) begin
          w_state_next = S_OUTPUT;
        end else if (w_tmo_hit) begin
          w_state_next = S_OUTPUT;
          w_abort      = 1'b1;
        end
      end
      S_OUTPUT: begin
        if (bus.res_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Fold every lane handshaking this cycle into the accumulator, lowest lane first.
  always_comb begin
    w_acc_next    = r_acc;
    w_loaded_next = r_acc_loaded;
    w_lane        = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      w_lane = ACC_W'($signed(bus.pe_out_data[i*RES_W +: RES_W]));
      if (w_out_hs[i]) begin
        case (r_mode)
          MODE_SUM: w_acc_next = w_acc_next + w_lane;
          MODE_MAX: if (!w_loaded_next || (w_lane > w_acc_next)) w_acc_next = w_lane;
          MODE_MIN: if (!w_loaded_next || (w_lane < w_acc_next)) w_acc_next = w_lane;
          default:  w_acc_next = w_acc_next;
        endcase
        w_loaded_next = 1'b1;
      end
    end
  end

  // NOTE: operand registers are reset as well, since they drive pe_in_a/pe_in_b directly and
  // must not expose stale or unknown data after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_mask       <= '0;
      r_mode       <= MODE_SUM;
      r_id         <= '0;
      r_issued     <= '0;
      r_collected  <= '0;
      r_acc        <= '0;
      r_acc_loaded <= 1'b0;
      r_tmo        <= '0;
      r_err        <= 1'b0;
    end else if (w_accept) begin
      r_a          <= bus.cmd_a;
      r_b          <= bus.cmd_b;
      r_mask       <= bus.cmd_mask;
      r_mode       <= mode_e'(bus.cmd_mode);
      r_id         <= bus.cmd_id;
      r_issued     <= '0;
      r_collected  <= '0;
      r_acc        <= '0;
      r_acc_loaded <= 1'b0;
      r_tmo        <= '0;
      r_err        <= w_bad_cmd;
    end else begin
      r_issued     <= r_issued | w_in_hs;
      r_collected  <= r_collected | w_out_hs;
      r_acc        <= w_acc_next;
      r_acc_loaded <= w_loaded_next;
      if (w_busy && !w_tmo_hit) begin
        r_tmo <= r_tmo + TMO_W'(1);
      end
      if (w_abort) begin
        r_err <= 1'b1;
      end
    end
  end

  a_res_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (bus.res_valid && !bus.res_ready) |=>
      (bus.res_valid && $stable(bus.res_data) && $stable(bus.res_id) && $stable(bus.res_err)));

  a_in_valid_masked : assert property (@(posedge clk) disable iff (!rst_n)
    (bus.pe_in_valid & ~r_mask) == '0);

  a_out_ready_masked : assert property (@(posedge clk) disable iff (!rst_n)
    (bus.pe_out_ready & ~r_mask) == '0);

endmodule

// File: tb/tb_pe_dispatch_ctrl.sv
// Directed bench for pe_dispatch_ctrl: a table of commands with hand-computed results, run
// through a small cycle-level PE model, plus a hand-written reset-in-COLLECT sequence.
module tb_pe_dispatch_ctrl;

  localparam int NUM_PE  = 4;
  localparam int DATA_W  = 16;
  localparam int RES_W   = 32;
  localparam int ACC_W   = 40;
  localparam int ID_W    = 4;
  localparam int TMO_CYC = 20;
  localparam int N_VEC   = 10;
  localparam int MAX_CYC = 60;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pe_dispatch_ctrl_if #(
    .NUM_PE(NUM_PE), .DATA_W(DATA_W), .RES_W(RES_W), .ACC_W(ACC_W), .ID_W(ID_W)
  ) bus ();

  pe_dispatch_ctrl #(
    .NUM_PE(NUM_PE), .DATA_W(DATA_W), .RES_W(RES_W), .ACC_W(ACC_W), .ID_W(ID_W),
    .TMO_CYC(TMO_CYC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0]        mask;
    logic [1:0]        mode;
    logic [3:0]        id;
    logic [3:0][15:0]  a;
    logic [15:0]       b;
    logic [3:0][31:0]  res;      // value each PE lane returns
    logic [3:0]        respond;  // lanes whose PE ever produces a result
    bit                stagger;  // lane i accepts issue only from cycle i+1
    logic [3:0]        en;       // lanes allowed to see valid/ready
    logic [39:0]       exp_data;
    bit                exp_err;
    int                exp_lat;  // cycles from accept edge to first res_valid sample
    int                exp_hs;   // cycles containing at least one result handshake
    int                hold;     // cycles res_ready is held low
  } vec_t;

  vec_t tbl[N_VEC];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] mask, input logic [1:0] mode, input logic [3:0] id,
                              input int r0, input int r1, input int r2, input int r3,
                              input logic [3:0] respond, input bit stagger,
                              input logic signed [39:0] exp_data, input bit exp_err,
                              input int exp_lat, input int exp_hs, input int hold);
    vec_t v;
    v.mask     = mask;
    v.mode     = mode;
    v.id       = id;
    v.a        = '0;
    v.b        = '0;
    v.res[0]   = r0;
    v.res[1]   = r1;
    v.res[2]   = r2;
    v.res[3]   = r3;
    v.respond  = respond;
    v.stagger  = stagger;
    v.en       = (mask == 4'h0 || mode == 2'd3) ? 4'h0 : mask;
    v.exp_data = exp_data;
    v.exp_err  = exp_err;
    v.exp_lat  = exp_lat;
    v.exp_hs   = exp_hs;
    v.hold     = hold;
    return v;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, " cmd_ready"},    64'(bus.cmd_ready),    64'd1);
    check({tag, " pe_in_valid"},  64'(bus.pe_in_valid),  64'd0);
    check({tag, " pe_out_ready"}, 64'(bus.pe_out_ready), 64'd0);
    check({tag, " res_valid"},    64'(bus.res_valid),    64'd0);
    check({tag, " res_data"},     64'(bus.res_data),     64'd0);
    check({tag, " res_id"},       64'(bus.res_id),       64'd0);
    check({tag, " res_err"},      64'(bus.res_err),      64'd0);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    logic [3:0] pend;
    logic [3:0] in_hs;
    logic [3:0] out_hs;
    int         cyc;
    int         hs_cyc;
    int         viol;
    int         opbad;
    int         stab;
    bit         got;
    string      tag;

    tag    = $sformatf("vec%0d", k);
    pend   = '0;
    hs_cyc = 0;
    viol   = 0;
    opbad  = 0;
    stab   = 0;
    got    = 1'b0;
    cyc    = 0;

    @(negedge clk);
    check({tag, " cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    // NOTE: inputs are driven with blocking assignments at the falling edge, well clear of
    // the rising edge where the design samples them.
    bus.cmd_valid = 1'b1;
    bus.cmd_mask  = v.mask;
    bus.cmd_mode  = v.mode;
    bus.cmd_id    = v.id;
    bus.cmd_a     = v.a;
    bus.cmd_b     = v.b;
    for (int i = 0; i < NUM_PE; i++) bus.pe_out_data[i*RES_W +: RES_W] = v.res[i];
    @(negedge clk);
    bus.cmd_valid = 1'b0;

    for (cyc = 1; cyc <= MAX_CYC; cyc++) begin
      if (((bus.pe_in_valid | bus.pe_out_ready) & ~v.en) != 4'h0) viol++;
      if (bus.res_valid) begin
        got = 1'b1;
        break;
      end
      for (int i = 0; i < NUM_PE; i++) bus.pe_in_ready[i] = v.stagger ? (cyc > i) : 1'b1;
      in_hs = bus.pe_in_valid & bus.pe_in_ready;
      for (int i = 0; i < NUM_PE; i++) begin
        if (in_hs[i] && (bus.pe_in_a[i*DATA_W +: DATA_W] !== v.a[i] ||
                         bus.pe_in_b[i*DATA_W +: DATA_W] !== v.b)) opbad++;
      end
      bus.pe_out_valid = pend & v.respond;
      out_hs = bus.pe_out_ready & bus.pe_out_valid;
      if (out_hs != 4'h0) hs_cyc++;
      pend = (pend & ~out_hs) | in_hs;
      @(negedge clk);
    end

    bus.pe_in_ready  = '0;
    bus.pe_out_valid = '0;
    check({tag, " res_valid seen"}, 64'(got), 64'd1);
    if (got) begin
      check({tag, " latency"},  64'(cyc),          64'(v.exp_lat));
      check({tag, " res_data"}, 64'(bus.res_data), 64'(v.exp_data));
      check({tag, " res_err"},  64'(bus.res_err),  64'(v.exp_err));
      check({tag, " res_id"},   64'(bus.res_id),   64'(v.id));
      for (int h = 0; h < v.hold; h++) begin
        @(negedge clk);
        if (!bus.res_valid || bus.res_data !== v.exp_data || bus.res_err !== v.exp_err ||
            bus.res_id !== v.id) stab++;
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      check({tag, " back to idle"}, 64'({bus.cmd_ready, bus.res_valid}), 64'b10);
    end
    check({tag, " masked lanes only"},  64'(viol),   64'd0);
    check({tag, " issued operands"},    64'(opbad),  64'd0);
    check({tag, " result hs cycles"},   64'(hs_cyc), 64'(v.exp_hs));
    check({tag, " held while stalled"}, 64'(stab),   64'd0);
  endtask

  task automatic reset_mid_collect();
    int busy;
    @(negedge clk);
    bus.cmd_mask    = 4'hF;
    bus.cmd_mode    = 2'd0;
    bus.cmd_id      = 4'd9;
    bus.cmd_a       = 64'h0004_0003_0002_0001;
    bus.cmd_b       = 16'd1;
    bus.cmd_valid   = 1'b1;
    bus.pe_in_ready = 4'hF;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("rstseq issuing", 64'(bus.pe_in_valid), 64'hF);
    @(negedge clk);
    check("rstseq collecting", 64'(bus.pe_out_ready), 64'hF);
    #2 rst_n = 1'b0;
    #1 check_reset_values("rstseq in reset");
    @(negedge clk);
    rst_n = 1'b1;
    bus.pe_out_valid = 4'hF;
    busy = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.pe_in_valid != 4'h0 || bus.pe_out_ready != 4'h0 || bus.res_valid || !bus.cmd_ready)
        busy++;
    end
    check("rstseq no residual activity", 64'(busy), 64'd0);
    bus.pe_out_valid = '0;
    bus.pe_in_ready  = '0;
  endtask

  initial begin
    bus.cmd_valid    = 1'b0;
    bus.cmd_a        = '0;
    bus.cmd_b        = '0;
    bus.cmd_mask     = '0;
    bus.cmd_mode     = '0;
    bus.cmd_id       = '0;
    bus.pe_in_ready  = '0;
    bus.pe_out_valid = '0;
    bus.pe_out_data  = '0;
    bus.res_ready    = 1'b0;

    //            mask   mode  id     r0    r1    r2    r3    resp  stg exp  err lat hs hold
    tbl[0] = mk(4'hF, 2'd0, 4'd3,     5,   10,   15,   20, 4'hF, 0,  50, 0,  4, 1, 0);
    tbl[1] = mk(4'h5, 2'd1, 4'd7,    -7,  111,   12,  222, 4'hF, 0,  12, 0,  4, 1, 2);
    tbl[2] = mk(4'hF, 2'd2, 4'd10,    3,   -9,    4,    0, 4'hF, 0,  -9, 0,  4, 1, 10);
    tbl[3] = mk(4'h0, 2'd0, 4'd1,     1,    2,    3,    4, 4'hF, 0,   0, 1,  1, 0, 0);
    tbl[4] = mk(4'hF, 2'd3, 4'd14,    1,    2,    3,    4, 4'hF, 0,   0, 1,  1, 0, 0);
    tbl[5] = mk(4'hF, 2'd0, 4'd5,   100,  200,  999,  300, 4'hB, 0, 600, 1, 21, 1, 0);
    tbl[6] = mk(4'hF, 2'd0, 4'd6,    10,  -20,   30,  -40, 4'hF, 1, -20, 0,  7, 1, 0);
    tbl[7] = mk(4'hF, 2'd1, 4'd8,    -5,   -3,   -8,   -4, 4'hF, 0,  -3, 0,  4, 1, 0);
    tbl[8] = mk(4'h8, 2'd2, 4'd15,    1,    2,    3,   77, 4'hF, 0,  77, 0,  4, 1, 0);
    tbl[9] = mk(4'hF, 2'd0, 4'd2,  -100,   30,   -1,    0, 4'hF, 0, -71, 0,  4, 1, 0);
    for (int k = 0; k < N_VEC; k++) begin
      for (int i = 0; i < NUM_PE; i++) tbl[k].a[i] = 16'(k * 16 + i + 1);
      tbl[k].b = 16'(k + 5);
    end

    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    for (int k = 0; k < N_VEC; k++) run_vec(tbl[k], k);
    reset_mid_collect();
    run_vec(tbl[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
